// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 systolic feeder.
//   DATA_SIZE_DEFAULT : default element / stream width
//   N                 : array dimension
//   FEED_CYCLES       : cycles needed to push one skewed 3x3 operand set (2N-1)
//   CNT_W / IDX_W     : widths of the shared beat/phase counter and element index
//   state_t           : feeder sequencing states
package systolic_pkg;
  localparam int DATA_SIZE_DEFAULT = 8;
  localparam int N                 = 3;
  localparam int FEED_CYCLES       = 2 * N - 1;
  localparam int CNT_W             = 4;
  localparam int IDX_W             = $clog2(N);

  typedef enum logic [2:0] {
    S_LOAD,
    S_CLR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/systolic_feeder_3x3_if.sv
// Operand load interface for the systolic feeder: one A/B element pair per
// valid/ready beat, row-major order.
//   master : operand source (drives in_valid, in_a, in_b; sees in_ready)
//   slave  : feeder (sees in_valid, in_a, in_b; drives in_ready)
interface systolic_feeder_3x3_if #(
  parameter int DATA_SIZE = systolic_pkg::DATA_SIZE_DEFAULT
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_a;
  logic [DATA_SIZE-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);
endinterface

// File: rtl/skew_mux.sv
// Selects element (t - OFFSET) of one stored row/column, or 0 when that index
// falls outside the vector or the feeder is not in its feed phase.
//   en   : feed phase active
//   t    : feed phase counter
//   vec  : N stored elements, index 0 first
//   elem : selected element
module skew_mux
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
  parameter int OFFSET    = 0
) (
  input  logic                         en,
  input  logic [CNT_W-1:0]             t,
  input  logic [N-1:0][DATA_SIZE-1:0]  vec,
  output logic [DATA_SIZE-1:0]         elem
);
  logic [CNT_W-1:0] idx;

  // t < OFFSET wraps to a large unsigned value, so one bound check covers both ends.
  assign idx = t - CNT_W'(OFFSET);

  always_comb begin
    elem = '0;
    if (en && (idx < CNT_W'(N))) begin
      elem = vec[idx[IDX_W-1:0]];
    end
  end
endmodule

// File: rtl/systolic_feeder_3x3.sv
// Operand sequencer for a 3x3 output-stationary systolic array.
// Buffers A and B (9 beats), clears the array accumulators for one cycle,
// feeds diagonally skewed row streams (a1..a3) and column streams (b1..b3),
// waits for the array to drain and pulses done. All outputs are registered.
//   clk, reset      : clock, asynchronous active-low reset
//   in_if (slave)   : in_valid / in_ready / in_a / in_b load handshake
//   a1..a3, b1..b3  : left-edge and top-edge array streams
//   arr_clr         : one-cycle accumulator clear for the array
//   busy            : high whenever not loading
//   done            : one-cycle pulse, array outputs hold A x B
module systolic_feeder_3x3
  import systolic_pkg::*;
#(
  parameter int DATA_SIZE    = DATA_SIZE_DEFAULT,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  systolic_feeder_3x3_if.slave  in_if,
  output logic [DATA_SIZE-1:0]  a1,
  output logic [DATA_SIZE-1:0]  a2,
  output logic [DATA_SIZE-1:0]  a3,
  output logic [DATA_SIZE-1:0]  b1,
  output logic [DATA_SIZE-1:0]  b2,
  output logic [DATA_SIZE-1:0]  b3,
  output logic                  arr_clr,
  output logic                  busy,
  output logic                  done
);
  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [N*N-1:0][DATA_SIZE-1:0]     a_buf_q, a_buf_d;
  logic [N*N-1:0][DATA_SIZE-1:0]     b_buf_q, b_buf_d;
  logic [N-1:0][DATA_SIZE-1:0]       a_q, a_d;
  logic [N-1:0][DATA_SIZE-1:0]       b_q, b_d;
  logic                              in_ready_q, in_ready_d;
  logic                              arr_clr_q, arr_clr_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              feed_d;

  // cnt counts load beats in LOAD, the phase t in FEED and drain cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    case (state_q)
      S_LOAD: begin
        if (in_if.in_valid && in_ready_q) begin
          a_buf_d[cnt_q] = in_if.in_a;
          b_buf_d[cnt_q] = in_if.in_b;
          if (cnt_q == CNT_W'(N * N - 1)) begin
            state_d = S_CLR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CLR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == CNT_W'(FEED_CYCLES - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up
  // with the state they describe.
  assign feed_d     = (state_d == S_FEED);
  assign in_ready_d = (state_d == S_LOAD);
  assign arr_clr_d  = (state_d == S_CLR);
  assign busy_d     = (state_d != S_LOAD);
  assign done_d     = (state_d == S_DONE);

  // Lane i: row i of A with skew i, column i of B with skew i.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N-1:0][DATA_SIZE-1:0] b_col;
    for (genvar r = 0; r < N; r++) begin : g_col
      assign b_col[r] = b_buf_q[r * N + i];
    end
    skew_mux #(.DATA_SIZE(DATA_SIZE), .OFFSET(i)) u_a_mux (
      .en   (feed_d),
      .t    (cnt_d),
      .vec  (a_buf_q[i * N +: N]),
      .elem (a_d[i])
    );
    skew_mux #(.DATA_SIZE(DATA_SIZE), .OFFSET(i)) u_b_mux (
      .en   (feed_d),
      .t    (cnt_d),
      .vec  (b_col),
      .elem (b_d[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_LOAD;
      cnt_q      <= '0;
      a_buf_q    <= '0;
      b_buf_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready_q <= 1'b1;
      arr_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_buf_q    <= a_buf_d;
      b_buf_q    <= b_buf_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_ready_q <= in_ready_d;
      arr_clr_q  <= arr_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign a1      = a_q[0];
  assign a2      = a_q[1];
  assign a3      = a_q[2];
  assign b1      = b_q[0];
  assign b2      = b_q[1];
  assign b3      = b_q[2];
  assign arr_clr = arr_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_systolic_feeder_3x3.sv
module tb_systolic_feeder_3x3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_3x3_if #(.DATA_SIZE(DW)) in_if ();

  logic [DW-1:0] a1, a2, a3, b1, b2, b3;
  logic          arr_clr, busy, done;

  systolic_feeder_3x3 #(.DATA_SIZE(DW), .DRAIN_CYCLES(3)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .in_if   (in_if),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .b1      (b1),
    .b2      (b2),
    .b3      (b3),
    .arr_clr (arr_clr),
    .busy    (busy),
    .done    (done)
  );

  // Behavioural 3x3 output-stationary array driven by the feeder streams.
  logic [DW-1:0] ae [3];
  logic [DW-1:0] be [3];
  logic [DW-1:0] ah [3][3];
  logic [DW-1:0] bv [3][3];
  logic [DW-1:0] ain [3][3];
  logic [DW-1:0] bin [3][3];
  int            acc [3][3];

  assign ae[0] = a1; assign ae[1] = a2; assign ae[2] = a3;
  assign be[0] = b1; assign be[1] = b2; assign be[2] = b3;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        ain[i][j] = '0;
        bin[i][j] = '0;
        ain[i][j] = (j == 0) ? ae[i] : ah[i][(j == 0) ? 0 : j - 1];
        bin[i][j] = (i == 0) ? be[j] : bv[(i == 0) ? 0 : i - 1][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (arr_clr) begin
          acc[i][j] <= 0;
          ah[i][j]  <= '0;
          bv[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + int'(ain[i][j]) * int'(bin[i][j]);
          ah[i][j]  <= ain[i][j];
          bv[i][j]  <= bin[i][j];
        end
      end
    end
  end

  typedef struct {
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    logic [8:0][31:0] c;
    bit               toggle;
  } vec_t;

  vec_t        vecs [5];
  logic [51:0] sb_q [$];
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record layout {a1,a2,a3,b1,b2,b3,arr_clr,busy,done,in_ready}.
  function automatic logic [51:0] dut_rec();
    return {a1, a2, a3, b1, b2, b3, arr_clr, busy, done, in_if.in_ready};
  endfunction

  // ph: 0 CLR, 1..5 FEED t=ph-1, 6..8 DRAIN, 9 DONE, 10 back in LOAD.
  function automatic logic [51:0] exp_rec(input logic [8:0][7:0] a, input logic [8:0][7:0] b, input int ph);
    logic [7:0] ea [3];
    logic [7:0] eb [3];
    int t;
    t = ph - 1;
    for (int r = 0; r < 3; r++) begin
      ea[r] = '0;
      eb[r] = '0;
      if (ph >= 1 && ph <= 5 && (t - r) >= 0 && (t - r) <= 2) begin
        ea[r] = a[r * 3 + (t - r)];
        eb[r] = b[(t - r) * 3 + r];
      end
    end
    return {ea[0], ea[1], ea[2], eb[0], eb[1], eb[2],
            1'(ph == 0), 1'(ph <= 9), 1'(ph == 9), 1'(ph == 10)};
  endfunction

  task automatic run_job(input int vi, input int abort_at);
    vec_t        v;
    logic [51:0] e;
    v = vecs[vi];
    for (int k = 0; k < 9; k++) begin
      if (v.toggle && k > 0) begin
        in_if.in_valid = 1'b0;
        in_if.in_a     = 8'($urandom);
        in_if.in_b     = 8'($urandom);
        chk($sformatf("job%0d_ready_gap%0d", vi, k), 64'(in_if.in_ready), 64'd1);
        @(posedge clk); #1;
      end
      in_if.in_valid = 1'b1;
      in_if.in_a     = v.a[k];
      in_if.in_b     = v.b[k];
      chk($sformatf("job%0d_ready_beat%0d", vi, k), 64'(in_if.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_if.in_valid = 1'b0;
    for (int ph = 0; ph < 11; ph++) sb_q.push_back(exp_rec(v.a, v.b, ph));
    for (int ph = 0; ph < 11; ph++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      chk($sformatf("job%0d_ph%0d", vi, ph), 64'(dut_rec()), 64'(e));
      if (ph == 9) begin
        for (int k = 0; k < 9; k++)
          chk($sformatf("job%0d_c%0d", vi, k + 1), 64'(acc[k / 3][k % 3]), 64'(v.c[k]));
      end
      if (ph == abort_at) return;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    for (int k = 0; k < 9; k++) begin
      vecs[0].a[k] = 8'(k + 1);
      vecs[0].b[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      vecs[0].c[k] = 32'(k + 1);
      vecs[2].a[k] = 8'd2;
      vecs[2].b[k] = 8'd3;
      vecs[2].c[k] = 32'd18;
      vecs[3].a[k] = (k % 4 == 0) ? 8'd1 : 8'd0;
      vecs[3].b[k] = 8'(k + 1);
      vecs[3].c[k] = 32'(k + 1);
      vecs[4].a[k] = 8'd255;
      vecs[4].b[k] = 8'd255;
      vecs[4].c[k] = 32'd195075;
    end
    vecs[0].toggle = 1'b0;
    vecs[1] = vecs[0];
    vecs[1].toggle = 1'b1;
    vecs[2].toggle = 1'b0;
    vecs[3].toggle = 1'b0;
    vecs[4].toggle = 1'b0;

    in_if.in_valid = 1'b0;
    in_if.in_a = '0;
    in_if.in_b = '0;
    #12;
    chk("reset_state", 64'(dut_rec()), 64'(exp_rec('0, '0, 10)));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 64'(dut_rec()), 64'(exp_rec('0, '0, 10)));

    for (int vi = 0; vi < 5; vi++) run_job(vi, -1);

    // Reset during FEED t=2, then confirm the job is abandoned.
    run_job(0, 3);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 64'(dut_rec()), 64'(exp_rec('0, '0, 10)));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_abort", 64'(nd), 64'd0);

    // Fresh job after the abort, then a second job back to back.
    run_job(0, -1);
    run_job(3, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
